// File: rtl/interrupt_controller.sv
// Eight-line interrupt controller: synchronised request capture, maskable pending
// register and a fixed-priority (line 0 highest) presenter with CPU acknowledge.
module interrupt_controller #(
   parameter int          EDGE_MODE  = 1,
   parameter logic [7:0]  MASK_RESET = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] irq_in,
   input  logic       mask_we,
   input  logic [7:0] mask_wdata,
   input  logic       ack,
   input  logic [2:0] ack_id,
   output logic [7:0] interruptions,
   output logic       irq_valid,
   output logic [2:0] irq_id,
   output logic [7:0] pending,
   output logic [7:0] mask
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   logic [7:0] sync1_q, sync1_d;
   logic [7:0] sync2_q, sync2_d;
   logic [7:0] prev_q,  prev_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] mask_q, mask_d;
   state_t     state_q, state_d;
   logic [2:0] irq_id_q, irq_id_d;
   logic       irq_valid_q, irq_valid_d;
   logic [7:0] interruptions_q, interruptions_d;

   logic [7:0] active;
   logic [2:0] lowest_idx;
   logic [7:0] ack_clr;

   always_comb begin
      sync1_d = irq_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      mask_d  = mask_we ? mask_wdata : mask_q;
   end

   // A set event and an ack clear on the same bit resolve in favour of the set.
   generate
      if (EDGE_MODE != 0) begin : g_edge
         always_comb pending_d = (pending_q & ~ack_clr) | (sync2_q & ~prev_q);
      end else begin : g_level
         always_comb pending_d = sync2_q;
      end
   endgenerate

   always_comb begin
      active     = pending_q & mask_q;
      lowest_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) lowest_idx = 3'(i);
      end
   end

   always_comb begin
      state_d         = state_q;
      irq_id_d        = irq_id_q;
      irq_valid_d     = irq_valid_q;
      interruptions_d = interruptions_q;
      ack_clr         = 8'h00;
      case (state_q)
         IDLE: begin
            if (active != 8'h00) begin
               state_d         = PRESENT;
               irq_id_d        = lowest_idx;
               irq_valid_d     = 1'b1;
               interruptions_d = 8'h01 << lowest_idx;
            end
         end
         PRESENT: begin
            // The presented line is frozen; only its ack or its own mask releases it.
            if (ack && (ack_id == irq_id_q)) begin
               ack_clr[irq_id_q] = 1'b1;
               state_d           = IDLE;
               irq_id_d          = 3'd0;
               irq_valid_d       = 1'b0;
               interruptions_d   = 8'h00;
            end else if (!mask_q[irq_id_q]) begin
               state_d         = IDLE;
               irq_id_d        = 3'd0;
               irq_valid_d     = 1'b0;
               interruptions_d = 8'h00;
            end
         end
         default: begin
            state_d         = IDLE;
            irq_id_d        = 3'd0;
            irq_valid_d     = 1'b0;
            interruptions_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q         <= 8'h00;
         sync2_q         <= 8'h00;
         prev_q          <= 8'h00;
         pending_q       <= 8'h00;
         mask_q          <= MASK_RESET;
         state_q         <= IDLE;
         irq_id_q        <= 3'd0;
         irq_valid_q     <= 1'b0;
         interruptions_q <= 8'h00;
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         prev_q          <= prev_d;
         pending_q       <= pending_d;
         mask_q          <= mask_d;
         state_q         <= state_d;
         irq_id_q        <= irq_id_d;
         irq_valid_q     <= irq_valid_d;
         interruptions_q <= interruptions_d;
      end
   end

   assign interruptions = interruptions_q;
   assign irq_valid     = irq_valid_q;
   assign irq_id        = irq_id_q;
   assign pending       = pending_q;
   assign mask          = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus random traffic, all
// checked against a sample-history reference model of the controller.
module tb_interrupt_controller;

   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       ack;
   logic [2:0] ack_id;
   logic [7:0] interruptions;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic [7:0] mask;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: the last three irq_in samples plus the controller's visible state.
   logic [7:0] h0, h1, h2;
   logic [7:0] m_pending, m_mask;
   bit         m_pres;
   int         m_pid;

   interrupt_controller dut (
      .clk          (clk),
      .reset        (reset),
      .irq_in       (irq_in),
      .mask_we      (mask_we),
      .mask_wdata   (mask_wdata),
      .ack          (ack),
      .ack_id       (ack_id),
      .interruptions(interruptions),
      .irq_valid    (irq_valid),
      .irq_id       (irq_id),
      .pending      (pending),
      .mask         (mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
      m_pending = 8'h00;
      m_mask    = 8'hFF;
      m_pres    = 1'b0;
      m_pid     = 0;
   endtask

   // A line counts as risen when the sample two edges back is 1 and three back is 0.
   task automatic model_step(input logic [7:0] irq, input logic we, input logic [7:0] wd,
                             input logic a, input logic [2:0] aid);
      logic [7:0] set_ev, clr;
      bit         np;
      int         npid;
      bit         found;
      set_ev = h1 & ~h2;
      clr    = 8'h00;
      np     = m_pres;
      npid   = m_pid;
      if (m_pres) begin
         if (a && (int'(aid) == m_pid)) begin
            clr[m_pid] = 1'b1;
            np = 1'b0;
         end else if (!m_mask[m_pid]) begin
            np = 1'b0;
         end
      end else if ((m_pending & m_mask) != 8'h00) begin
         found = 1'b0;
         for (int i = 0; i < 8; i++) begin
            if (!found && m_pending[i] && m_mask[i]) begin
               npid  = i;
               found = 1'b1;
            end
         end
         np = 1'b1;
      end
      m_pending = (m_pending & ~clr) | set_ev;
      if (we) m_mask = wd;
      m_pres = np;
      m_pid  = np ? npid : 0;
      h2 = h1; h1 = h0; h0 = irq;
   endtask

   task automatic check_model(input string where);
      logic [7:0] exp_int;
      exp_int = m_pres ? (8'h01 << m_pid) : 8'h00;
      check({where, ".interruptions"}, interruptions, exp_int);
      check({where, ".irq_valid"}, {7'd0, irq_valid}, {7'd0, m_pres});
      check({where, ".irq_id"}, {5'd0, irq_id}, m_pres ? 8'(m_pid) : 8'h00);
      check({where, ".pending"}, pending, m_pending);
      check({where, ".mask"}, mask, m_mask);
   endtask

   // Called near a falling edge; drives inputs, steps one rising edge, checks, returns at the next falling edge.
   task automatic cycle(input string where, input logic [7:0] irq, input logic we,
                        input logic [7:0] wd, input logic a, input logic [2:0] aid);
      irq_in = irq; mask_we = we; mask_wdata = wd; ack = a; ack_id = aid;
      @(posedge clk);
      model_step(irq, we, wd, a, aid);
      #1;
      check_model(where);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] r_irq;
      logic       r_we, r_ack;
      logic [7:0] r_wd;
      logic [2:0] r_aid;
      int         waited;

      reset = 1'b0; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; ack_id = 3'd0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst.interruptions", interruptions, 8'h00);
      check("rst.irq_valid", {7'd0, irq_valid}, 8'h00);
      check("rst.pending", pending, 8'h00);
      check("rst.mask", mask, 8'hFF);
      reset = 1'b1;

      // Single edge on line 2, then a stray ack, then a re-arm coinciding with the real ack.
      cycle("e2_c1", 8'h04, 0, 8'h00, 0, 3'd0);
      cycle("e2_c2", 8'h04, 0, 8'h00, 0, 3'd0);
      cycle("e2_c3", 8'h04, 0, 8'h00, 0, 3'd0);
      check("e2.pending_k2", pending, 8'h04);
      cycle("e2_c4", 8'h04, 0, 8'h00, 0, 3'd0);
      check("e2.presented", interruptions, 8'h04);
      check("e2.id", {5'd0, irq_id}, 8'd2);
      cycle("e2_bad_ack", 8'h00, 0, 8'h00, 1, 3'd5);
      check("e2.bad_ack_ignored", interruptions, 8'h04);
      cycle("e2_c6", 8'h04, 0, 8'h00, 0, 3'd0);
      cycle("e2_c7", 8'h04, 0, 8'h00, 0, 3'd0);
      cycle("e2_ack_set", 8'h04, 0, 8'h00, 1, 3'd2);
      check("e2.set_wins", pending, 8'h04);
      check("e2.idle_gap", interruptions, 8'h00);
      cycle("e2_c9", 8'h00, 0, 8'h00, 0, 3'd0);
      check("e2.represented", interruptions, 8'h04);
      cycle("e2_c10", 8'h00, 0, 8'h00, 1, 3'd2);
      check("e2.cleared", pending, 8'h00);

      // Masked line still goes pending and is presented once unmasked.
      cycle("m_c1", 8'h00, 1, 8'hFE, 0, 3'd0);
      cycle("m_c2", 8'h01, 0, 8'h00, 0, 3'd0);
      cycle("m_c3", 8'h00, 0, 8'h00, 0, 3'd0);
      cycle("m_c4", 8'h00, 0, 8'h00, 0, 3'd0);
      cycle("m_c5", 8'h00, 0, 8'h00, 0, 3'd0);
      check("m.pending_masked", pending, 8'h01);
      check("m.not_presented", interruptions, 8'h00);
      cycle("m_c6", 8'h00, 1, 8'hFF, 0, 3'd0);
      cycle("m_c7", 8'h00, 0, 8'h00, 0, 3'd0);
      check("m.unmasked_present", interruptions, 8'h01);
      cycle("m_c8", 8'h00, 0, 8'h00, 1, 3'd0);

      // Random traffic: sparse toggles, occasional mask writes, mostly-correct acks.
      r_irq = 8'h00;
      for (int n = 0; n < 2000; n++) begin
         for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
         end
         r_we  = ($urandom_range(0, 15) == 0);
         r_wd  = 8'($urandom) | 8'($urandom);
         r_ack = ($urandom_range(0, 3) == 0);
         r_aid = ($urandom_range(0, 9) < 7) ? 3'(m_pid) : 3'($urandom_range(0, 7));
         cycle("rand", r_irq, r_we, r_wd, r_ack, r_aid);
      end

      // Get something presented, then pull reset mid-presentation.
      cycle("pre_rst", 8'h00, 1, 8'hFF, 0, 3'd0);
      waited = 0;
      while (!m_pres && waited < 20) begin
         cycle("pre_rst_wait", 8'h20, 0, 8'h00, 0, 3'd0);
         waited++;
      end
      check("pre_rst.presenting", {7'd0, irq_valid}, 8'h01);
      reset  = 1'b0;
      irq_in = 8'h10;
      ack    = 1'b0;
      mask_we = 1'b0;
      #1;
      model_reset();
      check("async_rst.interruptions", interruptions, 8'h00);
      check("async_rst.irq_valid", {7'd0, irq_valid}, 8'h00);
      check("async_rst.irq_id", {5'd0, irq_id}, 8'h00);
      check("async_rst.pending", pending, 8'h00);
      check("async_rst.mask", mask, 8'hFF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cycle("rel_c1", 8'h10, 0, 8'h00, 0, 3'd0);
      cycle("rel_c2", 8'h10, 0, 8'h00, 0, 3'd0);
      cycle("rel_c3", 8'h10, 0, 8'h00, 0, 3'd0);
      check("rel.not_yet", {7'd0, irq_valid}, 8'h00);
      cycle("rel_c4", 8'h10, 0, 8'h00, 0, 3'd0);
      check("rel.presented", interruptions, 8'h10);
      check("rel.id", {5'd0, irq_id}, 8'd4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter EDGE_MODE, default 1, meaning 1 = rising-edge-triggered requests and 0 = level-triggered requests.
REQ-002 Parameter MASK_RESET, default 8'hFF, meaning the value loaded into the mask register on reset.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset.
REQ-005 Port irq_in, input, 8, raw request lines from timer and buttons; asynchronous to clk.
REQ-006 Port mask_we, input, 1, mask write strobe.
REQ-007 Port mask_wdata, input, 8, mask write data; bit set = line enabled.
REQ-008 Port ack, input, 1, single-cycle acknowledge pulse from the CPU.
REQ-009 Port ack_id, input, 3, index of the line being acknowledged.
REQ-010 Port interruptions, output, 8, registered one-hot request to the CPU; all zero when nothing is presented.
REQ-011 Port irq_valid, output, 1, high while a request is presented.
REQ-012 Port irq_id, output, 3, index of the presented line; 0 when irq_valid is low.
REQ-013 Port pending, output, 8, current pending register.
REQ-014 Port mask, output, 8, current mask register.

Function
REQ-015 Each irq_in bit shall pass through a 2-flop synchronizer; a third flop shall hold the previous synchronized value.
REQ-016 EDGE_MODE=1: a 0->1 transition on a synchronized bit shall set its pending bit; a rise before clock edge k shall give pending set after edge k+2.
REQ-017 EDGE_MODE=0: each pending bit shall equal its synchronized level, and ack shall not clear it.
REQ-018 mask_we shall load mask_wdata into mask at the next edge; the new mask shall be effective from the following cycle.
REQ-019 FSM states: IDLE and PRESENT.
REQ-020 IDLE -> PRESENT when (pending & mask) != 0; on the same edge, latch the lowest set index of (pending & mask) into irq_id; bit 0 has the highest priority.
REQ-021 In PRESENT, interruptions = one-hot(irq_id) and irq_valid = 1; both shall be registered outputs, with no combinational path from any input.
REQ-022 In PRESENT, irq_id shall remain frozen; a higher-priority arrival shall not pre-empt the presented line.
REQ-023 In PRESENT, ack=1 with ack_id == irq_id shall clear pending[irq_id] (EDGE_MODE=1) and return the FSM to IDLE at the next edge.
REQ-024 ack with a mismatched ack_id, or any ack while in IDLE, shall be ignored.
REQ-025 If a set event and an ack-clear hit the same pending bit on the same edge, the set shall win and the bit shall stay pending.
REQ-026 If mask[irq_id] becomes 0 while in PRESENT, the FSM shall withdraw to IDLE at the next edge and the pending bit shall be kept.
REQ-027 The FSM shall spend at least one cycle in IDLE between two presentations; interruptions shall be zero during that cycle.
REQ-028 Pending bits of masked lines shall still set and shall be presented once unmasked.
REQ-029 Pending bits shall never auto-clear; repeated edges on an already-pending line shall be absorbed.

Reset
REQ-030 reset=0 shall asynchronously force: synchronizer and previous-value flops = 0, pending = 0, mask = MASK_RESET, FSM = IDLE, interruptions = 0, irq_valid = 0, irq_id = 0.
REQ-031 Reset asserted mid-PRESENT shall drop the request immediately, and no ack shall be needed afterwards.
REQ-032 After reset release, a line already high shall count as a rising edge, because the synchronizer starts from 0.

Verification
REQ-033 irq_in=8'h04 rising before edge k -> pending=8'h04 after edge k+2; interruptions=8'h04, irq_valid=1, irq_id=2 after edge k+3.
REQ-034 irq_in=8'h0A rising together -> line 1 presented first; ack with ack_id=1 -> IDLE for one cycle -> interruptions=8'h08, irq_id=3.
REQ-035 While line 3 is presented, irq_in[0] rises -> interruptions stays 8'h08 until ack with ack_id=3, then 8'h01 is presented.
REQ-036 mask_wdata=8'hFE written, then irq_in[0] pulses -> pending=8'h01 and interruptions=0; write mask 8'hFF -> 8'h01 presented.
REQ-037 ack with ack_id=5 while line 2 is presented -> no change; a new edge on line 2 in the same cycle as a correct ack -> pending[2] stays 1 and line 2 is presented again after one IDLE cycle.
REQ-038 reset pulsed low while PRESENT -> all outputs 0 immediately and mask=8'hFF; with irq_in held at 8'h10 through release -> line 4 is presented 4 edges after release.
